// File: rtl/bus_master_port.sv
// Master-side endpoint of the two-master serial bus: takes one local command,
// requests the bus, shifts address/write data out or read data in, and returns a response.
module bus_master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  breq,
    input  logic                  bgrant,
    output logic                  bus_mode,
    output logic                  bus_wdata,
    output logic                  bus_wvalid,
    input  logic                  bus_rdata,
    input  logic                  bus_rvalid,
    input  logic                  sready
);
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE} state_t;

    state_t                state, state_n;
    logic                  is_write, is_write_n;
    logic [ADDR_WIDTH-1:0] addr_sh, addr_sh_n;
    logic [DATA_WIDTH-1:0] data_sh, data_sh_n;
    logic [DATA_WIDTH-1:0] rdata_sh, rdata_sh_n, rdata_shifted;
    logic [CW-1:0]         bit_cnt, bit_cnt_n;
    logic [TW-1:0]         wait_cnt, wait_cnt_n;
    logic                  breq_n, bus_wvalid_n, bus_wdata_n, bus_mode_n;
    logic                  rsp_valid_n, rsp_err_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_n;
    logic                  in_transfer, done_now, done_err;
    logic [DATA_WIDTH-1:0] done_data;
    logic                  unused_sready;

    // Slave readiness is already folded into the arbiter's grant decision.
    assign unused_sready = sready;
    assign req_ready     = (state == IDLE);
    assign in_transfer   = (state == ADDR) || (state == WDATA) || (state == RWAIT) || (state == RDATA);
    assign rdata_shifted = (rdata_sh >> 1) | (DATA_WIDTH'(bus_rdata) << (DATA_WIDTH - 1));

    always_comb begin
        state_n      = state;
        is_write_n   = is_write;
        addr_sh_n    = addr_sh;
        data_sh_n    = data_sh;
        rdata_sh_n   = rdata_sh;
        bit_cnt_n    = bit_cnt;
        wait_cnt_n   = wait_cnt;
        breq_n       = breq;
        bus_wvalid_n = bus_wvalid;
        bus_wdata_n  = bus_wdata;
        bus_mode_n   = bus_mode;
        rsp_valid_n  = 1'b0;
        rsp_err_n    = rsp_err;
        rsp_rdata_n  = rsp_rdata;
        done_now     = 1'b0;
        done_err     = 1'b0;
        done_data    = '0;

        // Losing the grant mid-transfer overrides whatever the current phase would do.
        if (in_transfer && !bgrant) begin
            done_now = 1'b1;
            done_err = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_write_n = req_write;
                        addr_sh_n  = req_addr;
                        data_sh_n  = req_wdata;
                        breq_n     = 1'b1;
                        state_n    = REQ;
                    end
                end
                REQ: begin
                    if (bgrant) begin
                        bus_wvalid_n = 1'b1;
                        bus_wdata_n  = addr_sh[0];
                        bus_mode_n   = is_write;
                        addr_sh_n    = addr_sh >> 1;
                        bit_cnt_n    = '0;
                        state_n      = ADDR;
                    end
                end
                ADDR: begin
                    if (bit_cnt != ADDR_LAST) begin
                        bus_wdata_n = addr_sh[0];
                        addr_sh_n   = addr_sh >> 1;
                        bit_cnt_n   = bit_cnt + CW'(1);
                    end else if (is_write) begin
                        bus_wdata_n = data_sh[0];
                        data_sh_n   = data_sh >> 1;
                        bit_cnt_n   = '0;
                        state_n     = WDATA;
                    end else begin
                        bus_wvalid_n = 1'b0;
                        bus_wdata_n  = 1'b0;
                        bit_cnt_n    = '0;
                        wait_cnt_n   = '0;
                        state_n      = RWAIT;
                    end
                end
                WDATA: begin
                    if (bit_cnt != DATA_LAST) begin
                        bus_wdata_n = data_sh[0];
                        data_sh_n   = data_sh >> 1;
                        bit_cnt_n   = bit_cnt + CW'(1);
                    end else begin
                        done_now = 1'b1;
                    end
                end
                // Only the wait for the first bit is timed; gaps inside RDATA are not.
                RWAIT, RDATA: begin
                    if (bus_rvalid) begin
                        rdata_sh_n = rdata_shifted;
                        if (bit_cnt == DATA_LAST) begin
                            done_now  = 1'b1;
                            done_data = rdata_shifted;
                        end else begin
                            bit_cnt_n = bit_cnt + CW'(1);
                            state_n   = RDATA;
                        end
                    end else if (state == RWAIT) begin
                        if (wait_cnt == WAIT_LAST) begin
                            done_now = 1'b1;
                            done_err = 1'b1;
                        end else begin
                            wait_cnt_n = wait_cnt + TW'(1);
                        end
                    end
                end
                DONE: begin
                    rsp_err_n = 1'b0;
                    state_n   = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        if (done_now) begin
            breq_n       = 1'b0;
            bus_wvalid_n = 1'b0;
            bus_wdata_n  = 1'b0;
            bus_mode_n   = 1'b0;
            rsp_valid_n  = 1'b1;
            rsp_err_n    = done_err;
            rsp_rdata_n  = done_err ? '0 : done_data;
            state_n      = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            is_write   <= 1'b0;
            addr_sh    <= '0;
            data_sh    <= '0;
            rdata_sh   <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            breq       <= 1'b0;
            bus_wvalid <= 1'b0;
            bus_wdata  <= 1'b0;
            bus_mode   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state      <= state_n;
            is_write   <= is_write_n;
            addr_sh    <= addr_sh_n;
            data_sh    <= data_sh_n;
            rdata_sh   <= rdata_sh_n;
            bit_cnt    <= bit_cnt_n;
            wait_cnt   <= wait_cnt_n;
            breq       <= breq_n;
            bus_wvalid <= bus_wvalid_n;
            bus_wdata  <= bus_wdata_n;
            bus_mode   <= bus_mode_n;
            rsp_valid  <= rsp_valid_n;
            rsp_err    <= rsp_err_n;
            rsp_rdata  <= rsp_rdata_n;
        end
    end
endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: plays arbiter and slave, compares the serial stream
// and responses with a simple arithmetic model of each transaction.
module tb_bus_master_port;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          breq, bgrant, bus_mode, bus_wdata, bus_wvalid;
    logic          bus_rdata, bus_rvalid, sready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .breq(breq), .bgrant(bgrant), .bus_mode(bus_mode), .bus_wdata(bus_wdata),
        .bus_wvalid(bus_wvalid), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .sready(sready)
    );

    typedef struct packed {
        int          nrsp;
        logic        err;
        logic [7:0]  rdata;
        logic [19:0] bits;
        int          nbits;
        logic        mode_bad;
        logic        breq_at_rsp;
        logic        ready_after;
        logic        wait_bad;
        logic        busy_ready_bad;
        int          rwait_to_rsp;
        int          grant_to_wvalid;
        int          k_last_bit;
        int          k_rsp;
    } obs_t;

    // Serial stream the bus should carry: address LSB first, then write data.
    function automatic logic [19:0] model_bits(input logic wr, input logic [11:0] a, input logic [7:0] d);
        return 20'(a) + (wr ? 20'(d) * 20'd4096 : 20'd0);
    endfunction

    // Issues one command and acts as arbiter and slave until the response arrives.
    task automatic do_transfer(input logic wr, input logic [11:0] a, input logic [7:0] d,
                               input logic [7:0] sdata, input int gdelay, input int drop_at,
                               input int first_rv, input int gmin, input int gmax,
                               input logic noise, output obs_t o);
        int k, kg, rcyc, sent, gap;
        o = '0;
        o.rwait_to_rsp = -1; o.grant_to_wvalid = -1; o.k_last_bit = -1; o.k_rsp = -1;
        kg = -1; rcyc = -1; sent = 0; gap = first_rv;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(negedge clk);
        k = 0;
        while (o.nrsp == 0 && k < 400) begin
            if (rcyc >= 0) rcyc++;
            else if (!wr && o.nbits == AW && bus_wvalid === 1'b0) rcyc = 0;
            if (req_ready !== 1'b0) o.busy_ready_bad = 1'b1;
            if (kg < 0 && (breq !== 1'b1 || bus_wvalid !== 1'b0)) o.wait_bad = 1'b1;
            if (bus_wvalid === 1'b1) begin
                if (o.nbits == 0) o.grant_to_wvalid = k - kg;
                if (o.nbits < 20) o.bits[o.nbits] = bus_wdata;
                if (bus_mode !== wr) o.mode_bad = 1'b1;
                o.nbits++;
                o.k_last_bit = k;
            end
            if (rsp_valid === 1'b1) begin
                o.nrsp = 1; o.err = rsp_err; o.rdata = rsp_rdata;
                o.breq_at_rsp = breq; o.rwait_to_rsp = rcyc; o.k_rsp = k;
            end
            if (o.nrsp != 0) bgrant = 1'b0;
            else if (kg < 0 && k >= gdelay) begin bgrant = 1'b1; kg = k; end
            else if (drop_at >= 0 && bus_wvalid === 1'b1 && o.nbits == drop_at + 1) bgrant = 1'b0;
            if (rcyc >= 0 && sent < DW && o.nrsp == 0) begin
                if (gap == 0) begin
                    bus_rvalid = 1'b1; bus_rdata = sdata[sent]; sent++;
                    gap = int'($urandom_range(gmax, gmin));
                end else begin
                    bus_rvalid = 1'b0; gap--;
                end
            end else if (noise && rcyc < 0 && o.nrsp == 0) begin
                bus_rvalid = 1'($urandom); bus_rdata = 1'($urandom);
            end else begin
                bus_rvalid = 1'b0; bus_rdata = 1'b0;
            end
            req_valid = (noise && o.nrsp == 0) ? 1'($urandom) : 1'b0;
            req_write = 1'($urandom); req_addr = 12'($urandom); req_wdata = 8'($urandom);
            @(negedge clk);
            k++;
        end
        if (o.nrsp == 0) begin
            bgrant = 1'b0; bus_rvalid = 1'b0; req_valid = 1'b0;
            rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        end else begin
            @(negedge clk);
            o.ready_after = req_ready;
            if (rsp_valid === 1'b1) o.nrsp++;
            repeat (2) begin
                @(negedge clk);
                if (rsp_valid === 1'b1) o.nrsp++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({breq, bus_wvalid, bus_wdata, bus_mode, rsp_valid, rsp_err} !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %b want 000000", {breq, bus_wvalid, bus_wdata, bus_mode, rsp_valid, rsp_err});
        end
        checks++;
        if (rsp_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 00", rsp_rdata); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, breq} !== 2'b10) begin errors++; $display("[TB] FAIL post_reset_idle: got %b want 10", {req_ready, breq}); end
    endtask

    task automatic test_write_basic();
        obs_t o;
        do_transfer(1'b1, 12'h5A3, 8'hC6, 8'h00, 2, -1, 0, 0, 0, 1'b0, o);
        checks++;
        if (o.bits !== model_bits(1'b1, 12'h5A3, 8'hC6) || o.nbits != AW + DW) begin
            errors++; $display("[TB] FAIL write_stream: got %h/%0d want %h/%0d", o.bits, o.nbits, model_bits(1'b1, 12'h5A3, 8'hC6), AW + DW);
        end
        checks++;
        if (o.mode_bad !== 1'b0) begin errors++; $display("[TB] FAIL write_mode: got bad=%b want 0", o.mode_bad); end
        checks++;
        if (o.nrsp != 1 || o.err !== 1'b0 || o.breq_at_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL write_rsp: got n=%0d err=%b breq=%b want 1/0/0", o.nrsp, o.err, o.breq_at_rsp);
        end
        checks++;
        if (o.k_rsp - o.k_last_bit != 1 || o.grant_to_wvalid != 1) begin
            errors++; $display("[TB] FAIL write_timing: got done_gap=%0d grant_gap=%0d want 1/1", o.k_rsp - o.k_last_bit, o.grant_to_wvalid);
        end
        checks++;
        if (o.busy_ready_bad !== 1'b0 || o.ready_after !== 1'b1) begin
            errors++; $display("[TB] FAIL write_ready: got busy=%b after=%b want 0/1", o.busy_ready_bad, o.ready_after);
        end
    endtask

    task automatic test_read_gapped();
        obs_t o;
        do_transfer(1'b0, 12'h801, 8'h00, 8'hA5, 1, -1, 4, 1, 1, 1'b0, o);
        checks++;
        if (o.bits !== model_bits(1'b0, 12'h801, 8'h00) || o.nbits != AW || o.mode_bad !== 1'b0) begin
            errors++; $display("[TB] FAIL read_addr: got %h/%0d mode_bad=%b want %h/%0d", o.bits, o.nbits, o.mode_bad, model_bits(1'b0, 12'h801, 8'h00), AW);
        end
        checks++;
        if (o.rdata !== 8'hA5 || o.err !== 1'b0) begin
            errors++; $display("[TB] FAIL read_data: got %h err=%b want a5 err=0", o.rdata, o.err);
        end
        checks++;
        if (o.nrsp != 1) begin errors++; $display("[TB] FAIL read_pulses: got %0d want 1", o.nrsp); end
    endtask

    task automatic test_read_timeout();
        obs_t o;
        logic [11:0] a;
        a = 12'($urandom);
        do_transfer(1'b0, a, 8'h00, 8'h00, 0, -1, 100000, 0, 0, 1'b0, o);
        checks++;
        if (o.nrsp != 1 || o.err !== 1'b1 || o.rdata !== 8'h00) begin
            errors++; $display("[TB] FAIL timeout_rsp: got n=%0d err=%b data=%h want 1/1/00", o.nrsp, o.err, o.rdata);
        end
        checks++;
        if (o.rwait_to_rsp != TO || o.breq_at_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_timing: got %0d breq=%b want %0d breq=0", o.rwait_to_rsp, o.breq_at_rsp, TO);
        end
    endtask

    task automatic test_delayed_grant();
        obs_t o;
        logic [11:0] a;
        logic [7:0]  d;
        a = 12'($urandom); d = 8'($urandom);
        do_transfer(1'b1, a, d, 8'h00, 40, -1, 0, 0, 0, 1'b0, o);
        checks++;
        if (o.wait_bad !== 1'b0) begin errors++; $display("[TB] FAIL grant_wait: got bad=%b want 0", o.wait_bad); end
        checks++;
        if (o.grant_to_wvalid != 1) begin errors++; $display("[TB] FAIL grant_start: got %0d want 1", o.grant_to_wvalid); end
        checks++;
        if (o.bits !== model_bits(1'b1, a, d) || o.nrsp != 1 || o.err !== 1'b0) begin
            errors++; $display("[TB] FAIL grant_xfer: got %h n=%0d err=%b want %h 1 0", o.bits, o.nrsp, o.err, model_bits(1'b1, a, d));
        end
    endtask

    task automatic test_grant_loss();
        obs_t o;
        logic [11:0] a;
        a = 12'($urandom);
        do_transfer(1'b1, a, 8'($urandom), 8'h00, 1, 5, 0, 0, 0, 1'b0, o);
        checks++;
        if (o.nbits != 6 || o.bits !== 20'(a & 12'h03F)) begin
            errors++; $display("[TB] FAIL loss_bits: got %h/%0d want %h/6", o.bits, o.nbits, 20'(a & 12'h03F));
        end
        checks++;
        if (o.nrsp != 1 || o.err !== 1'b1 || o.k_rsp - o.k_last_bit != 1) begin
            errors++; $display("[TB] FAIL loss_rsp: got n=%0d err=%b gap=%0d want 1/1/1", o.nrsp, o.err, o.k_rsp - o.k_last_bit);
        end
        checks++;
        if (o.ready_after !== 1'b1 || o.breq_at_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL loss_ready: got ready=%b breq=%b want 1/0", o.ready_after, o.breq_at_rsp);
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        int   n, k, pulses;
        logic [11:0] a;
        logic [7:0]  d;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h3C7; req_wdata = 8'h5E;
        @(negedge clk);
        req_valid = 1'b0; bgrant = 1'b1;
        n = 0; k = 0;
        while (n < 14 && k < 100) begin
            @(negedge clk);
            if (bus_wvalid === 1'b1) n++;
            k++;
        end
        checks++;
        if (n < 14) begin errors++; $display("[TB] FAIL arst_reach_wdata: got %0d bits want 14", n); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({breq, bus_wvalid, rsp_valid, req_ready} !== 4'b0001) begin
            errors++; $display("[TB] FAIL arst_async: got %b want 0001", {breq, bus_wvalid, rsp_valid, req_ready});
        end
        @(negedge clk);
        bgrant = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || breq === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL arst_quiet: got activity=%0d ready=%b want 0/1", pulses, req_ready);
        end
        a = 12'($urandom); d = 8'($urandom);
        do_transfer(1'b1, a, d, 8'h00, 1, -1, 0, 0, 0, 1'b0, o);
        checks++;
        if (o.bits !== model_bits(1'b1, a, d) || o.nrsp != 1 || o.err !== 1'b0) begin
            errors++; $display("[TB] FAIL arst_recover: got %h n=%0d err=%b want %h 1 0", o.bits, o.nrsp, o.err, model_bits(1'b1, a, d));
        end
    endtask

    task automatic test_random_traffic();
        obs_t o;
        logic        wr;
        logic [11:0] a;
        logic [7:0]  d, s;
        for (int t = 0; t < 25; t++) begin
            wr = 1'($urandom); a = 12'($urandom); d = 8'($urandom); s = 8'($urandom);
            sready = 1'($urandom);
            do_transfer(wr, a, d, s, int'($urandom_range(6, 0)), -1, int'($urandom_range(10, 0)), 0, 3, 1'b1, o);
            checks++;
            if (o.bits !== model_bits(wr, a, d) || o.nbits != (wr ? AW + DW : AW)) begin
                errors++; $display("[TB] FAIL rand_stream[%0d]: got %h/%0d want %h/%0d", t, o.bits, o.nbits, model_bits(wr, a, d), wr ? AW + DW : AW);
            end
            checks++;
            if (o.nrsp != 1 || o.err !== 1'b0 || o.rdata !== (wr ? 8'h00 : s)) begin
                errors++; $display("[TB] FAIL rand_rsp[%0d]: got n=%0d err=%b data=%h want 1 0 %h", t, o.nrsp, o.err, o.rdata, wr ? 8'h00 : s);
            end
            checks++;
            if ({o.mode_bad, o.busy_ready_bad, o.wait_bad, o.breq_at_rsp, o.ready_after} !== 5'b00001 || o.grant_to_wvalid != 1) begin
                errors++; $display("[TB] FAIL rand_flags[%0d]: got %b grant_gap=%0d want 00001 1", t,
                                   {o.mode_bad, o.busy_ready_bad, o.wait_bad, o.breq_at_rsp, o.ready_after}, o.grant_to_wvalid);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        bgrant = 1'b0; bus_rdata = 1'b0; bus_rvalid = 1'b0; sready = 1'b1;
        test_reset();
        test_write_basic();
        test_read_gapped();
        test_read_timeout();
        test_delayed_grant();
        test_grant_loss();
        test_async_reset();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
